uart_rx: RTL

- UART receiver; the downstream counterpart of the UART transmitter, using the same frame format and parity controls.
- Oversamples the serial line with a 16x baud tick and recovers 8N1 or 8E1/8O1 frames (LSB first).
- Delivers each byte with valid, parity, framing and overrun status to the register/bus side.
- Sits between the rxd pad and the UART register block.

---
 rtl/uart_rx.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 16x-oversampled UART receiver, 8N1 / 8E1 / 8O1, LSB first,
//               with parity, framing and overrun status for the register side.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_en,
    input  logic       n_parity,
    input  logic       ev_parity,
    input  logic       baud16_tick,
    input  logic       rxd,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       rx_busy
);

    localparam int              C_TW    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [C_TW-1:0] C_SAMP0 = C_TW'(OVERSAMPLE / 2 - 1);
    localparam logic [C_TW-1:0] C_SAMP1 = C_TW'(OVERSAMPLE / 2);
    localparam logic [C_TW-1:0] C_SAMP2 = C_TW'(OVERSAMPLE / 2 + 1);
    localparam logic [C_TW-1:0] C_LAST  = C_TW'(OVERSAMPLE - 1);
    localparam logic [C_TW-1:0] C_ONE   = C_TW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t          r_state;
    logic            r_rxd_meta;
    logic            r_rxd_s;
    logic [C_TW-1:0] r_tcnt;
    logic [2:0]      r_bcnt;
    logic            r_samp0;
    logic            r_samp1;
    logic [7:0]      r_shift;
    logic            r_perr;
    logic            r_npar;
    logic            r_evpar;
    logic            r_en_q;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_parity_err;
    logic            r_frame_err;
    logic            r_overrun;
    logic            r_busy;

    logic [C_TW-1:0] w_tcnt_nxt;
    logic            w_bit;
    logic            w_par_exp;

    always_comb begin
        w_tcnt_nxt = (r_tcnt == C_LAST) ? '0 : r_tcnt + C_ONE;
        // majority vote: two stored samples plus the live one on the decision tick
        w_bit      = (r_samp0 & r_samp1) | (r_samp0 & r_rxd_s) | (r_samp1 & r_rxd_s);
        w_par_exp  = r_evpar ? (^r_shift) : ~(^r_shift);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_s    <= r_rxd_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_tcnt       <= '0;
            r_bcnt       <= '0;
            r_samp0      <= 1'b1;
            r_samp1      <= 1'b1;
            r_shift      <= '0;
            r_perr       <= 1'b0;
            r_npar       <= 1'b1;
            r_evpar      <= 1'b0;
            r_en_q       <= 1'b1;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_en_q <= rx_en;
            if (!rx_en) begin
                r_state      <= S_IDLE;
                r_tcnt       <= '0;
                r_bcnt       <= '0;
                r_samp0      <= 1'b1;
                r_samp1      <= 1'b1;
                r_shift      <= '0;
                r_perr       <= 1'b0;
                r_data       <= '0;
                r_valid      <= 1'b0;
                r_parity_err <= 1'b0;
                r_frame_err  <= 1'b0;
                r_overrun    <= 1'b0;
                r_busy       <= 1'b0;
            end else begin
                if (rx_ack) begin
                    r_valid   <= 1'b0;
                    r_overrun <= 1'b0;
                end
                // enabled onto a low line: wait for it to go high before hunting a start
                if (!r_en_q && !r_rxd_s) begin
                    r_state <= S_BREAK;
                    r_busy  <= 1'b1;
                end else if (baud16_tick) begin
                    case (r_state)
                        S_IDLE: begin
                            if (!r_rxd_s) begin
                                r_tcnt  <= '0;
                                r_state <= S_START;
                                r_busy  <= 1'b1;
                            end
                        end
                        S_BREAK: begin
                            if (r_rxd_s) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                        default: begin
                            r_tcnt <= w_tcnt_nxt;
                            if (r_tcnt == C_SAMP0) r_samp0 <= r_rxd_s;
                            if (r_tcnt == C_SAMP1) r_samp1 <= r_rxd_s;
                            if (r_tcnt == C_SAMP2) begin
                                case (r_state)
                                    S_START: begin
                                        if (w_bit) begin
                                            r_state <= S_IDLE;
                                            r_busy  <= 1'b0;
                                        end else begin
                                            r_state <= S_DATA;
                                            r_bcnt  <= '0;
                                            r_npar  <= n_parity;
                                            r_evpar <= ev_parity;
                                            r_perr  <= 1'b0;
                                        end
                                    end
                                    S_DATA: begin
                                        r_shift <= {w_bit, r_shift[7:1]};
                                        r_bcnt  <= r_bcnt + 3'd1;
                                        if (r_bcnt == 3'd7)
                                            r_state <= r_npar ? S_STOP : S_PARITY;
                                    end
                                    S_PARITY: begin
                                        r_perr  <= (w_bit != w_par_exp);
                                        r_state <= S_STOP;
                                    end
                                    S_STOP: begin
                                        // commit overrides a same-cycle ack
                                        r_data       <= r_shift;
                                        r_valid      <= 1'b1;
                                        r_parity_err <= r_npar ? 1'b0 : r_perr;
                                        r_frame_err  <= ~w_bit;
                                        if (r_valid && !rx_ack)
                                            r_overrun <= 1'b1;
                                        r_state      <= w_bit ? S_IDLE : S_BREAK;
                                        r_busy       <= ~w_bit;
                                    end
                                    default: begin
                                        r_state <= S_IDLE;
                                        r_busy  <= 1'b0;
                                    end
                                endcase
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign rx_data     = r_data;
    assign rx_valid    = r_valid;
    assign parity_err  = r_parity_err;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun;
    assign rx_busy     = r_busy;

endmodule
`default_nettype wire
